// File: rtl/vga_pkg.sv
// Shared VGA constants, motion FSM state type and the box colour palette.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned V_ACTIVE = 600;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_X,
        MOVE_Y,
        COMMIT
    } move_state_t;

    // Eight-entry box palette, {R,G,B} 4 bits each.
    function automatic logic [11:0] palette_rgb(input logic [2:0] idx);
        logic [11:0] rgb;
        case (idx)
            3'd0:    rgb = 12'hF00;
            3'd1:    rgb = 12'h0F0;
            3'd2:    rgb = 12'h00F;
            3'd3:    rgb = 12'hFF0;
            3'd4:    rgb = 12'h0FF;
            3'd5:    rgb = 12'hF0F;
            3'd6:    rgb = 12'hFFF;
            default: rgb = 12'hF80;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/box_pixel_renderer_if.sv
// Timing-controller inputs and VGA pin outputs of the box renderer.
interface box_pixel_renderer_if;

    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        visible;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    modport master (
        output display_col, display_row, visible, hsync, vsync,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        input  display_col, display_row, visible, hsync, vsync,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a configurable reset value.
module vga_delay_line #(
    parameter int unsigned          WIDTH     = 1,
    parameter int unsigned          DEPTH     = 2,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Shift din through DEPTH registers; reset fills every stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= RESET_VAL;
            end
        end else begin
            stages[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/box_pixel_renderer.sv
// Bouncing box renderer: per-frame motion FSM plus a 2-cycle pixel pipeline.
module box_pixel_renderer
    import vga_pkg::*;
#(
    parameter int unsigned BOX_W  = 32,
    parameter int unsigned BOX_H  = 32,
    parameter int unsigned X0     = 100,
    parameter int unsigned Y0     = 100,
    parameter int unsigned STEP   = 2,
    parameter logic [11:0] BG_RGB = 12'h00F
) (
    input  logic                 clock,
    input  logic                 reset,
    box_pixel_renderer_if.slave  vga,
    input  logic                 pause,
    output logic                 frame_tick
);

    localparam logic [12:0] X_LIMIT  = 13'(H_ACTIVE - BOX_W);
    localparam logic [11:0] X_LIMIT12 = 12'(H_ACTIVE - BOX_W);
    localparam logic [11:0] Y_LIMIT  = 12'(V_ACTIVE - BOX_H);
    localparam logic [10:0] Y_LIMIT11 = 11'(V_ACTIVE - BOX_H);

    move_state_t state;
    move_state_t state_next;

    logic        vsync_q;

    logic [11:0] box_x;
    logic [10:0] box_y;
    logic [11:0] nx;
    logic [10:0] ny;
    logic        dx;
    logic        dy;
    logic        hit;
    logic [2:0]  color_idx;

    logic        ld_x;
    logic        ld_y;
    logic        commit;
    logic [12:0] x_sum;
    logic [11:0] y_sum;
    logic [11:0] x_next;
    logic [10:0] y_next;
    logic        dx_next;
    logic        dy_next;
    logic        x_hit;
    logic        y_hit;

    logic [12:0] col13;
    logic [12:0] row13;
    logic [12:0] bx13;
    logic [12:0] by13;
    logic        inside_d;
    logic        inside_q;
    logic        vis_q;
    logic [1:0]  sync_d;
    logic [11:0] rgb_q;

    // Detect the vsync falling edge and emit a one-cycle frame tick.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_q    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_q    <= vga.vsync;
            frame_tick <= vsync_q & ~vga.vsync;
        end
    end

    // Motion FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Motion FSM next state: one X step, one Y step, then commit per frame.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick && !pause) state_next = MOVE_X;
            MOVE_X:  state_next = MOVE_Y;
            MOVE_Y:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Motion FSM outputs: load strobes and the clamped next position per axis.
    always_comb begin
        ld_x    = (state == MOVE_X);
        ld_y    = (state == MOVE_Y);
        commit  = (state == COMMIT);

        x_sum   = {1'b0, box_x} + 13'(STEP);
        x_next  = box_x;
        dx_next = dx;
        x_hit   = 1'b0;
        if (dx) begin
            if (x_sum >= X_LIMIT) begin
                x_next  = X_LIMIT12;
                dx_next = 1'b0;
                x_hit   = 1'b1;
            end else begin
                x_next  = x_sum[11:0];
            end
        end else begin
            if (box_x < 12'(STEP)) begin
                x_next  = '0;
                dx_next = 1'b1;
                x_hit   = 1'b1;
            end else begin
                x_next  = box_x - 12'(STEP);
            end
        end

        y_sum   = {1'b0, box_y} + 12'(STEP);
        y_next  = box_y;
        dy_next = dy;
        y_hit   = 1'b0;
        if (dy) begin
            if (y_sum >= Y_LIMIT) begin
                y_next  = Y_LIMIT11;
                dy_next = 1'b0;
                y_hit   = 1'b1;
            end else begin
                y_next  = y_sum[10:0];
            end
        end else begin
            if (box_y < 11'(STEP)) begin
                y_next  = '0;
                dy_next = 1'b1;
                y_hit   = 1'b1;
            end else begin
                y_next  = box_y - 11'(STEP);
            end
        end
    end

    // Motion datapath: stage nx/ny, publish position only at commit.
    // A shared hit flag makes a corner bounce advance the colour only once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            box_x     <= 12'(X0);
            box_y     <= 11'(Y0);
            nx        <= 12'(X0);
            ny        <= 11'(Y0);
            dx        <= 1'b1;
            dy        <= 1'b1;
            hit       <= 1'b0;
            color_idx <= '0;
        end else begin
            if (ld_x) begin
                nx <= x_next;
                dx <= dx_next;
                if (x_hit) hit <= 1'b1;
            end
            if (ld_y) begin
                ny <= y_next;
                dy <= dy_next;
                if (y_hit) hit <= 1'b1;
            end
            if (commit) begin
                box_x <= nx;
                box_y <= ny;
                if (hit) color_idx <= color_idx + 3'd1;
                hit   <= 1'b0;
            end
        end
    end

    // Box hit-test in 13-bit arithmetic so the right/bottom edge cannot wrap.
    always_comb begin
        col13    = {1'b0, vga.display_col};
        row13    = {2'b0, vga.display_row};
        bx13     = {1'b0, box_x};
        by13     = {2'b0, box_y};
        inside_d = (col13 >= bx13) && (col13 < bx13 + 13'(BOX_W)) &&
                   (row13 >= by13) && (row13 < by13 + 13'(BOX_H));
    end

    // Pixel stage 1: register the hit-test result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inside_q <= 1'b0;
        end else begin
            inside_q <= inside_d;
        end
    end

    vga_delay_line #(
        .WIDTH     (1),
        .DEPTH     (1),
        .RESET_VAL (1'b0)
    ) u_vis_delay (
        .clock (clock),
        .reset (reset),
        .din   (vga.visible),
        .dout  (vis_q)
    );

    vga_delay_line #(
        .WIDTH     (2),
        .DEPTH     (2),
        .RESET_VAL (2'b11)
    ) u_sync_delay (
        .clock (clock),
        .reset (reset),
        .din   ({vga.hsync, vga.vsync}),
        .dout  (sync_d)
    );

    // Pixel stage 2: blank, box colour or background.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rgb_q <= '0;
        end else if (!vis_q) begin
            rgb_q <= '0;
        end else if (inside_q) begin
            rgb_q <= palette_rgb(color_idx);
        end else begin
            rgb_q <= BG_RGB;
        end
    end

    assign vga.vga_r  = rgb_q[11:8];
    assign vga.vga_g  = rgb_q[7:4];
    assign vga.vga_b  = rgb_q[3:0];
    assign vga.vga_hs = sync_d[1];
    assign vga.vga_vs = sync_d[0];

endmodule

// File: tb/tb_box_pixel_renderer.sv
// Scoreboard bench for box_pixel_renderer: default instance plus a corner-start instance.
module tb_box_pixel_renderer;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int unsigned due;
    } sb_entry_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic pause = 1'b0;
    logic frame_tick;
    logic frame_tick_c;

    int unsigned cyc    = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    sb_entry_t sb[$];
    sb_entry_t mon_e;

    // Reference model of the default instance.
    int m_x;
    int m_y;
    bit m_dx;
    bit m_dy;
    int m_ci;

    logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                             12'h0FF, 12'hF0F, 12'hFFF, 12'hF80};

    box_pixel_renderer_if bus ();
    box_pixel_renderer_if bus_c ();

    box_pixel_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .vga        (bus),
        .pause      (pause),
        .frame_tick (frame_tick)
    );

    box_pixel_renderer #(
        .X0 (767),
        .Y0 (567)
    ) dut_c (
        .clock      (clock),
        .reset      (reset),
        .vga        (bus_c),
        .pause      (pause),
        .frame_tick (frame_tick_c)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_inputs(input int col, input int row, input bit vis, input bit hs, input bit vs);
        bus.display_col   = 12'(col);
        bus.display_row   = 11'(row);
        bus.visible       = vis;
        bus.hsync         = hs;
        bus.vsync         = vs;
        bus_c.display_col = 12'(col);
        bus_c.display_row = 11'(row);
        bus_c.visible     = vis;
        bus_c.hsync       = hs;
        bus_c.vsync       = vs;
    endtask

    function automatic logic [11:0] exp_rgb(input int col, input int row, input bit vis);
        if (!vis) return 12'h000;
        if (col >= m_x && col < m_x + 32 && row >= m_y && row < m_y + 32) return pal[m_ci];
        return 12'h00F;
    endfunction

    task automatic model_reset();
        m_x = 100; m_y = 100; m_dx = 1; m_dy = 1; m_ci = 0;
    endtask

    task automatic model_frame();
        bit h;
        h = 0;
        if (m_dx) begin
            if (m_x + 2 >= 768) begin m_x = 768; m_dx = 0; h = 1; end
            else m_x = m_x + 2;
        end else begin
            if (m_x < 2) begin m_x = 0; m_dx = 1; h = 1; end
            else m_x = m_x - 2;
        end
        if (m_dy) begin
            if (m_y + 2 >= 568) begin m_y = 568; m_dy = 0; h = 1; end
            else m_y = m_y + 2;
        end else begin
            if (m_y < 2) begin m_y = 0; m_dy = 1; h = 1; end
            else m_y = m_y - 2;
        end
        if (h) m_ci = (m_ci + 1) % 8;
    endtask

    // Drive one pixel and queue what the RGB/sync pins must show two cycles later.
    task automatic drive_px(input int col, input int row, input bit vis, input bit hs, input bit vs);
        sb_entry_t e;
        @(posedge clock);
        #1;
        set_inputs(col, row, vis, hs, vs);
        e.rgb = exp_rgb(col, row, vis);
        e.hs  = hs;
        e.vs  = vs;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic flush_sb();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    // One vsync falling edge; checks the tick and the position four cycles later.
    task automatic do_frame(input bit mid_pause);
        int n;
        bit got;
        int old_x;
        int old_y;
        int old_ci;
        old_x  = m_x;
        old_y  = m_y;
        old_ci = m_ci;
        @(posedge clock);
        #1;
        bus.vsync   = 1'b0;
        bus_c.vsync = 1'b0;
        got = 0;
        n   = 0;
        while (!got && n < 8) begin
            @(negedge clock);
            if (frame_tick) got = 1;
            n++;
        end
        check("tick_seen", got, 1);
        @(negedge clock);
        check("tick_width", frame_tick, 0);
        if (mid_pause) pause = 1'b1;
        repeat (2) @(negedge clock);
        check("x_hold", dut.box_x, old_x);
        check("y_hold", dut.box_y, old_y);
        @(negedge clock);
        if (mid_pause || !pause) model_frame();
        check("box_x", dut.box_x, m_x);
        check("box_y", dut.box_y, m_y);
        check("color_idx", dut.color_idx, m_ci);
        check("dx", dut.dx, m_dx);
        @(posedge clock);
        #1;
        bus.vsync   = 1'b1;
        bus_c.vsync = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    // Compare every queued expectation once its pipeline latency has elapsed.
    always @(negedge clock) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, mon_e.rgb);
            check("vga_hs", bus.vga_hs, mon_e.hs);
            check("vga_vs", bus.vga_vs, mon_e.vs);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        set_inputs(0, 0, 0, 1, 1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 12'h000);
        check("rst_hs", bus.vga_hs, 1);
        check("rst_vs", bus.vga_vs, 1);
        check("rst_tick", frame_tick, 0);
        check("rst_box_x", dut.box_x, 100);
        check("rst_box_y", dut.box_y, 100);
        check("rst_ci", dut.color_idx, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // First update: both axes +2, no bounce.
        do_frame(0);
        check("c_box_x", dut_c.box_x, 768);
        check("c_box_y", dut_c.box_y, 568);
        check("c_ci", dut_c.color_idx, 1);
        check("c_dx", dut_c.dx, 0);
        check("c_dy", dut_c.dy, 0);

        // Box edges around (102,102)..(133,133) and blanking.
        drive_px(102, 102, 1, 1, 1);
        drive_px(134, 102, 1, 1, 1);
        drive_px(101, 102, 1, 1, 1);
        drive_px(133, 133, 1, 1, 1);
        drive_px(133, 134, 1, 1, 1);
        drive_px(102, 101, 1, 1, 1);
        drive_px(900, 102, 0, 1, 1);
        for (int c = 90; c < 140; c++) drive_px(c, 110, 1, 1, 1);
        flush_sb();

        // Horizontal blanking with an hsync pulse on cols 855..978.
        for (int c = 840; c <= 990; c++) drive_px(c, 300, 0, !(c >= 855 && c <= 978), 1);
        flush_sb();

        // Second frame: corner instance rebounds to 766/566 with colour unchanged.
        do_frame(0);
        check("c2_box_x", dut_c.box_x, 766);
        check("c2_box_y", dut_c.box_y, 566);
        check("c2_ci", dut_c.color_idx, 1);

        // Paused frames: tick still fires, nothing moves.
        pause = 1'b1;
        repeat (3) do_frame(0);
        pause = 1'b0;

        // Pause raised after the update started: that update still lands.
        do_frame(1);
        check("mid_pause_x", dut.box_x, 106);
        pause = 1'b0;
        do_frame(0);

        // Pixel stream inside the moved box with hsync low, then a mid-line reset.
        for (int k = 0; k < 4; k++) drive_px(m_x + 1 + k, m_y + 1, 1, 0, 1);
        flush_sb();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("mr_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 12'h000);
        check("mr_hs", bus.vga_hs, 1);
        check("mr_vs", bus.vga_vs, 1);
        check("mr_box_x", dut.box_x, 100);
        sb.delete();
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rel_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 12'h000);
        check("rel_hs", bus.vga_hs, 1);
        drive_px(101, 101, 1, 1, 1);
        drive_px(132, 131, 1, 0, 1);
        drive_px(132, 132, 1, 1, 1);
        flush_sb();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/box_pixel_renderer.md
Name: box_pixel_renderer

Overview:
- Sits directly downstream of the 800x600@72 Hz VGA timing controller in the 50 MHz clock domain.
- Consumes the controller's display_col, display_row, visible, hsync and vsync.
- Draws a solid square that bounces around the visible field, with a palette colour that changes on each wall hit, over a fixed background.
- Drives the 12-bit RGB pins and the timing-aligned sync pins.

Parameters:
- H_ACTIVE, 800, visible columns
- V_ACTIVE, 600, visible rows
- BOX_W, 32, box width in pixels
- BOX_H, 32, box height in pixels
- X0, 100, box left edge after reset
- Y0, 100, box top edge after reset
- STEP, 2, pixels moved per axis per frame
- BG_RGB, 12'h00F, background colour {R,G,B} 4 bits each

Ports:
- clock  in  1  50 MHz pixel clock
- reset  in  1  asynchronous, active-low reset
- display_col  in  12  current column from timing controller
- display_row  in  11  current row from timing controller
- visible  in  1  pixel is inside the active field
- hsync  in  1  controller hsync, active-low
- vsync  in  1  controller vsync, active-low
- pause  in  1  high: freeze box position and colour
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync delayed to align with RGB
- vga_vs  out  1  vsync delayed to align with RGB
- frame_tick  out  1  one-cycle pulse on each vsync falling edge

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - RGB = 0; vga_hs = 1; vga_vs = 1; frame_tick = 0.
  - box_x = X0 (12 bit), box_y = Y0 (11 bit); dx = +, dy = +.
  - colour index = 0; FSM = IDLE; sync pipeline filled with 1.
- Frame tick:
  - vsync_q is the registered copy of vsync.
  - frame_tick = vsync_q & ~vsync, registered, so high for exactly 1 cycle per frame.
- Motion FSM, states IDLE, MOVE_X, MOVE_Y, COMMIT:
  - IDLE -> MOVE_X when frame_tick=1 and pause=0; otherwise remain in IDLE.
  - MOVE_X: nx = box_x ± STEP.
    - If dx=+ and nx >= H_ACTIVE-BOX_W: nx = H_ACTIVE-BOX_W, dx = -, hit = 1.
    - If dx=- and box_x < STEP (underflow): nx = 0, dx = +, hit = 1.
  - MOVE_Y: same rule against V_ACTIVE-BOX_H and 0, using dy.
  - COMMIT: box_x/box_y <= nx/ny; if hit, colour index +1 (3-bit, wraps 7 -> 0); clear hit; -> IDLE.
  - A corner hit (both axes in one frame) increments the colour index once only.
  - frame_tick arriving while not in IDLE is ignored (cannot occur in legal timing).
  - Position registers change only in COMMIT, so the displayed box never tears within a frame.
- Pixel pipeline, 2-cycle latency:
  - Stage 1 registers: inside = (col >= box_x) & (col < box_x+BOX_W) & (row >= box_y) & (row < box_y+BOX_H), plus visible.
  - Compares use 13-bit arithmetic, so box_x+BOX_W never wraps.
  - Stage 2 output mux: !visible -> 12'h000; inside -> PALETTE[colour index]; else BG_RGB.
- Sync alignment: hsync and vsync pass through 2 flops each, so vga_hs/vga_vs align with RGB for the same pixel.
- pause=1 blocks IDLE -> MOVE_X. Raising pause mid-update lets the current update complete.
- Mid-frame reset forces outputs to reset values immediately. After release, the first valid RGB appears 2 cycles later.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants H_ACTIVE=800 and V_ACTIVE=600, shared with the timing controller.
  - The 8-entry 12-bit PALETTE: F00, 0F0, 00F, FF0, 0FF, F0F, FFF, F80.
  - FSM state enum.
- One sub-module, vga_delay_line (param WIDTH, DEPTH, reset value), used for the 2-stage sync delay and the visible delay.

Test Plan:
- Reset release, hold pause=0, one vsync falling edge -> frame_tick pulses 1 cycle; box_x=102, box_y=102 four cycles after the tick; colour index 0.
- col=102, row=102, visible=1 after the first update -> RGB=F00 two cycles later; col=134 (outside box) -> RGB=00F.
- visible=0 at col=900 -> RGB=000. An hsync low pulse on cols 855..978 -> vga_hs low on exactly those pixels' RGB cycles (2-cycle delay).
- box_x=767 with dx=+ (force via frames) -> box_x=768 next frame, dx=-, colour index 1, next frame box_x=766.
- Corner: box_x=767, box_y=567, both axes + -> box_x=768, box_y=568, colour index +1 only, both directions negative.
- pause=1 across 3 vsync edges -> frame_tick still pulses, position/colour unchanged. Assert reset mid-line -> RGB=0 and vga_hs=vga_vs=1 in the same cycle.
